// File: rtl/frame_pkg.sv
// frame_pkg: shared types and defaults for the frame checker
package frame_pkg;
  typedef enum logic [1:0] {HUNT, PAYLOAD, CSUM} state_t;
  typedef struct packed {
    logic [7:0] sync;
    logic [7:0] len;
  } header_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/frame_checker_if.sv
// frame_checker_if: word stream in/out, frame status and statistics
interface frame_checker_if #(parameter int CNT_W = 16);
  logic [15:0] data_in;
  logic data_in_vld;
  logic data_in_rdy;
  logic [15:0] data_out;
  logic data_out_vld;
  logic data_out_last;
  logic data_out_rdy;
  logic frame_ok;
  logic frame_err;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;
  logic [CNT_W-1:0] cnt_drop;
  modport master (
    output data_in, data_in_vld, data_out_rdy,
    input data_in_rdy, data_out, data_out_vld, data_out_last,
    input frame_ok, frame_err, cnt_ok, cnt_err, cnt_drop
  );
  modport slave (
    input data_in, data_in_vld, data_out_rdy,
    output data_in_rdy, data_out, data_out_vld, data_out_last,
    output frame_ok, frame_err, cnt_ok, cnt_err, cnt_drop
  );
endinterface

// File: rtl/frame_out_reg.sv
// frame_out_reg: single-entry valid/ready register for a payload word plus last flag
module frame_out_reg (
  input  logic clk,
  input  logic rst,
  input  logic [15:0] in_data,
  input  logic in_last,
  input  logic in_vld,
  output logic in_rdy,
  output logic [15:0] out_data,
  output logic out_last,
  output logic out_vld,
  input  logic out_rdy
);
  assign in_rdy = !out_vld || out_rdy;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else if (in_vld && in_rdy) begin
      out_vld <= 1'b1;
      out_last <= in_last;
      out_data <= in_data;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end
endmodule

// File: rtl/frame_checker.sv
// frame_checker: parses header/payload/checksum frames, forwards payload, reports status
module frame_checker
  import frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  frame_checker_if.slave bus
);
  state_t state, state_nx;
  header_t hdr;
  logic [15:0] sum;
  logic [7:0] rem;
  logic out_in_rdy, acc, hdr_ok, hunt_acc, load, csum_acc, match;
  assign hdr = header_t'(bus.data_in);
  assign bus.data_in_rdy = state == PAYLOAD ? out_in_rdy : 1'b1;
  assign acc = bus.data_in_vld && bus.data_in_rdy;
  assign hdr_ok = hdr.sync == SYNC_BYTE && hdr.len != 8'd0;
  assign hunt_acc = acc && state == HUNT;
  assign load = acc && state == PAYLOAD;
  assign csum_acc = acc && state == CSUM;
  assign match = bus.data_in == sum;
  always_comb begin
    state_nx = state;
    state_nx = state == HUNT ? (hunt_acc && hdr_ok ? PAYLOAD : HUNT)
             : state == PAYLOAD ? (load && rem == 8'd1 ? CSUM : PAYLOAD)
             : (csum_acc ? HUNT : CSUM);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      sum <= '0;
      rem <= '0;
      bus.frame_ok <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.cnt_ok <= '0;
      bus.cnt_err <= '0;
      bus.cnt_drop <= '0;
    end else begin
      state <= state_nx;
      sum <= hunt_acc ? 16'd0 : load ? sum + bus.data_in : sum;
      rem <= hunt_acc && hdr_ok ? hdr.len : load ? rem - 8'd1 : rem;
      bus.frame_ok <= csum_acc && match;
      bus.frame_err <= csum_acc && !match;
      bus.cnt_ok <= bus.cnt_ok + CNT_W'(csum_acc && match && !(&bus.cnt_ok));
      bus.cnt_err <= bus.cnt_err + CNT_W'(csum_acc && !match && !(&bus.cnt_err));
      bus.cnt_drop <= bus.cnt_drop + CNT_W'(hunt_acc && !hdr_ok && !(&bus.cnt_drop));
    end
  end
  frame_out_reg u_out (
    .clk(clk),
    .rst(rst),
    .in_data(bus.data_in),
    .in_last(rem == 8'd1),
    .in_vld(bus.data_in_vld && state == PAYLOAD),
    .in_rdy(out_in_rdy),
    .out_data(bus.data_out),
    .out_last(bus.data_out_last),
    .out_vld(bus.data_out_vld),
    .out_rdy(bus.data_out_rdy)
  );
endmodule

// File: tb/tb_frame_checker.sv
// tb_frame_checker: directed frame scenarios with hand-computed expectations
module tb_frame_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int n_ok = 0;
  int n_err = 0;
  logic [16:0] outq[$];
  frame_checker_if #(.CNT_W(16)) ifc ();
  frame_checker #(.SYNC_BYTE(8'hA5), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(ifc));
  always #5 clk = ~clk;
  // samples one time unit before each rising edge, after all drives have settled
  always @(negedge clk) begin
    #4;
    if (ifc.data_out_vld && ifc.data_out_rdy) outq.push_back({ifc.data_out_last, ifc.data_out});
    if (ifc.frame_ok) n_ok++;
    if (ifc.frame_err) n_err++;
    tests++;
    if (ifc.frame_ok && ifc.frame_err) begin
      fails++;
      $display("FAIL both_pulses: ok=%b err=%b required not both 1", ifc.frame_ok, ifc.frame_err);
    end
  end
  task automatic send(input logic [15:0] w);
    int t = 0;
    @(negedge clk);
    ifc.data_in = w;
    ifc.data_in_vld = 1'b1;
    #1;
    while (!ifc.data_in_rdy && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: word %h not accepted within 50 cycles", w);
    end
    @(posedge clk);
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    ifc.data_in_vld = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic test_reset;
    ifc.data_in = '0;
    ifc.data_in_vld = 1'b0;
    ifc.data_out_rdy = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({ifc.data_out_vld, ifc.data_out_last, ifc.data_out, ifc.frame_ok, ifc.frame_err} !== 20'h0) begin
      fails++;
      $display("FAIL reset_outputs: got vld=%b last=%b data=%h ok=%b err=%b required all 0",
               ifc.data_out_vld, ifc.data_out_last, ifc.data_out, ifc.frame_ok, ifc.frame_err);
    end
    tests++;
    if ({ifc.cnt_ok, ifc.cnt_err, ifc.cnt_drop} !== 48'h0) begin
      fails++;
      $display("FAIL reset_counters: got %h %h %h required 0", ifc.cnt_ok, ifc.cnt_err, ifc.cnt_drop);
    end
    tests++;
    if (ifc.data_in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL reset_rdy: got %b required 1", ifc.data_in_rdy);
    end
    rst = 1'b0;
  endtask
  task automatic test_good;
    logic [16:0] exp [2] = '{17'h01234, 17'h10001};
    outq.delete();
    send(16'hA502); send(16'h1234); send(16'h0001); send(16'h1235);
    @(negedge clk);
    ifc.data_in_vld = 1'b0;
    #1;
    tests++;
    if (ifc.frame_ok !== 1'b1 || ifc.frame_err !== 1'b0) begin
      fails++;
      $display("FAIL good_pulse: got ok=%b err=%b required ok=1 err=0", ifc.frame_ok, ifc.frame_err);
    end
    tests++;
    if (ifc.cnt_ok !== 16'd1) begin
      fails++;
      $display("FAIL good_cnt_ok: got %0d required 1", ifc.cnt_ok);
    end
    @(negedge clk);
    #1;
    tests++;
    if (ifc.frame_ok !== 1'b0) begin
      fails++;
      $display("FAIL good_pulse_width: frame_ok got %b required 0 on second cycle", ifc.frame_ok);
    end
    tests++;
    if (outq.size() != 2) begin
      fails++;
      $display("FAIL good_out_count: got %0d required 2", outq.size());
    end else for (int i = 0; i < 2; i++) begin
      tests++;
      if (outq[i] !== exp[i]) begin
        fails++;
        $display("FAIL good_out[%0d]: got %h required %h", i, outq[i], exp[i]);
      end
    end
  endtask
  task automatic test_bad_csum;
    int e0 = n_err;
    outq.delete();
    send(16'hA501); send(16'hFFFF); send(16'h0000);
    idle(3);
    tests++;
    if (n_err != e0 + 1) begin
      fails++;
      $display("FAIL bad_pulse: got %0d err pulses required 1", n_err - e0);
    end
    tests++;
    if (ifc.cnt_err !== 16'd1 || ifc.cnt_ok !== 16'd1) begin
      fails++;
      $display("FAIL bad_counts: got err=%0d ok=%0d required err=1 ok=1", ifc.cnt_err, ifc.cnt_ok);
    end
    tests++;
    if (outq.size() != 1 || outq[0] !== 17'h1FFFF) begin
      fails++;
      $display("FAIL bad_out: got size %0d first %h required 1 word 1ffff", outq.size(), outq.size() ? outq[0] : 17'h0);
    end
  endtask
  task automatic test_sum_wrap;
    int k0 = n_ok;
    int e0 = n_err;
    send(16'hA502); send(16'hFFFF); send(16'h0002); send(16'h0001);
    idle(3);
    tests++;
    if (n_ok != k0 + 1 || n_err != e0) begin
      fails++;
      $display("FAIL wrap_pulse: got ok+%0d err+%0d required ok+1 err+0", n_ok - k0, n_err - e0);
    end
    tests++;
    if (ifc.cnt_ok !== 16'd2) begin
      fails++;
      $display("FAIL wrap_cnt_ok: got %0d required 2", ifc.cnt_ok);
    end
  endtask
  task automatic test_hunt;
    int k0 = n_ok;
    outq.delete();
    send(16'h1111); send(16'hA500);
    send(16'hA501); send(16'h00AA); send(16'h00AA);
    idle(3);
    tests++;
    if (ifc.cnt_drop !== 16'd2) begin
      fails++;
      $display("FAIL hunt_drop: got %0d required 2", ifc.cnt_drop);
    end
    tests++;
    if (outq.size() != 1 || outq[0] !== 17'h100AA) begin
      fails++;
      $display("FAIL hunt_out: got size %0d first %h required 1 word 100aa", outq.size(), outq.size() ? outq[0] : 17'h0);
    end
    tests++;
    if (n_ok != k0 + 1 || ifc.cnt_ok !== 16'd3) begin
      fails++;
      $display("FAIL hunt_ok: got pulses %0d cnt_ok %0d required 1 and 3", n_ok - k0, ifc.cnt_ok);
    end
  endtask
  task automatic test_backpressure;
    logic [16:0] exp [3] = '{17'h00010, 17'h00020, 17'h10030};
    int k0 = n_ok;
    outq.delete();
    send(16'hA503); send(16'h0010);
    @(negedge clk);
    ifc.data_in_vld = 1'b0;
    ifc.data_out_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      tests++;
      if (ifc.data_in_rdy !== 1'b0 || ifc.data_out_vld !== 1'b1 || ifc.data_out !== 16'h0010 || ifc.data_out_last !== 1'b0) begin
        fails++;
        $display("FAIL stall[%0d]: got rdy=%b vld=%b data=%h last=%b required 0 1 0010 0",
                 c, ifc.data_in_rdy, ifc.data_out_vld, ifc.data_out, ifc.data_out_last);
      end
    end
    ifc.data_out_rdy = 1'b1;
    send(16'h0020); send(16'h0030); send(16'h0060);
    idle(3);
    tests++;
    if (outq.size() != 3) begin
      fails++;
      $display("FAIL bp_out_count: got %0d required 3", outq.size());
    end else for (int i = 0; i < 3; i++) begin
      tests++;
      if (outq[i] !== exp[i]) begin
        fails++;
        $display("FAIL bp_out[%0d]: got %h required %h", i, outq[i], exp[i]);
      end
    end
    tests++;
    if (n_ok != k0 + 1 || ifc.cnt_ok !== 16'd4) begin
      fails++;
      $display("FAIL bp_ok: got pulses %0d cnt_ok %0d required 1 and 4", n_ok - k0, ifc.cnt_ok);
    end
  endtask
  task automatic test_back_to_back;
    int k0 = n_ok;
    time t0;
    outq.delete();
    send(16'hA501); send(16'h0007); send(16'h0007);
    t0 = $time;
    send(16'hA501);
    tests++;
    if ($time - t0 != 10) begin
      fails++;
      $display("FAIL b2b_gap: header accepted %0t after checksum required 10", $time - t0);
    end
    send(16'h0009); send(16'h0009);
    idle(3);
    tests++;
    if (n_ok != k0 + 2 || ifc.cnt_ok !== 16'd6) begin
      fails++;
      $display("FAIL b2b_ok: got pulses %0d cnt_ok %0d required 2 and 6", n_ok - k0, ifc.cnt_ok);
    end
    tests++;
    if (outq.size() != 2 || outq[0] !== 17'h10007 || outq[1] !== 17'h10009) begin
      fails++;
      $display("FAIL b2b_out: got size %0d required 2 words 10007 10009", outq.size());
    end
  endtask
  task automatic test_mid_reset;
    int k0, e0;
    @(negedge clk);
    ifc.data_out_rdy = 1'b0;
    send(16'hA503); send(16'h0100);
    @(negedge clk);
    ifc.data_in_vld = 1'b0;
    #1;
    tests++;
    if (ifc.data_out_vld !== 1'b1) begin
      fails++;
      $display("FAIL mr_pre_vld: got %b required 1", ifc.data_out_vld);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (ifc.data_out_vld !== 1'b0 || {ifc.cnt_ok, ifc.cnt_err, ifc.cnt_drop} !== 48'h0) begin
      fails++;
      $display("FAIL mr_async: got vld=%b ok=%0d err=%0d drop=%0d required all 0",
               ifc.data_out_vld, ifc.cnt_ok, ifc.cnt_err, ifc.cnt_drop);
    end
    @(negedge clk);
    rst = 1'b0;
    ifc.data_out_rdy = 1'b1;
    k0 = n_ok;
    e0 = n_err;
    outq.delete();
    repeat (3) @(negedge clk);
    tests++;
    if (n_ok != k0 || n_err != e0 || outq.size() != 0) begin
      fails++;
      $display("FAIL mr_no_pulse: got ok+%0d err+%0d out %0d required all 0", n_ok - k0, n_err - e0, outq.size());
    end
    send(16'hA501); send(16'h0042); send(16'h0042);
    idle(3);
    tests++;
    if (n_ok != k0 + 1 || ifc.cnt_ok !== 16'd1 || outq.size() != 1 || outq[0] !== 17'h10042) begin
      fails++;
      $display("FAIL mr_recover: got pulses %0d cnt_ok %0d out %0d required 1 1 1",
               n_ok - k0, ifc.cnt_ok, outq.size());
    end
  endtask
  initial begin
    test_reset;
    test_good;
    test_bad_csum;
    test_sum_wrap;
    test_hunt;
    test_backpressure;
    test_back_to_back;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
